dff_scan_seq: RTL and testbench
===============================

// Module: dff_scan_seq
// PURPOSE
// - On-FPGA sequencer for the DUT DFF-chain PISO readout; generates clear/load/shift_clk/save_data that the RPi currently bit-bangs.
// - Sits between the top-level and the chip PISO pins (clear0/1, load0/1, shift_clk0/1) and the DFF data-save/output path (save_data).
// - One start strobe runs a full scan: optional clear, parallel load, CHAIN_LEN shift pulses, one save strobe.
// PARAMETERS
// - CHAIN_LEN  16  shift_clk pulses per scan (>=1)
// - SHIFT_DIV  4   CLK cycles per tick; every phase lasts exactly 1 tick (>=1)
// - CNT_W      16  width of completed-scan counter
// PORTS
// - CLK        in   1      system clock (CLK_REG domain, 50 MHz)
// - RST_B      in   1      asynchronous active-low reset
// - start      in   1      1-cycle request; accepted only in IDLE
// - do_clear   in   1      sampled with start; 1 = run CLEAR phase first
// - abort      in   1      synchronous abort, any state -> IDLE
// - cont       in   1      continuous rescan request (used only with DFF_SCAN_CONT_EN)
// - clear      out  1      PISO clear, high for 1 tick
// - load       out  1      PISO parallel load, high for 1 tick
// - shift_clk  out  1      PISO shift clock, 50% duty, period 2 ticks
// - save_data  out  1      1-CLK strobe to DFF data-save path at scan end
// - busy       out  1      high in every state except IDLE
// - done       out  1      1-CLK pulse, coincident with save_data
// - scan_cnt   out  CNT_W  completed scans, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; scan_cnt 0; tick and bit counters 0.
// - All outputs registered; asserted from the CLK edge entering the state.
// - Tick counter cleared on leaving IDLE; tick = terminal count every SHIFT_DIV cycles; SHIFT_DIV=1 -> tick every cycle.
// - States: IDLE, CLEAR, LOAD, SHIFT_HI, SHIFT_LO, SAVE.
//   IDLE: start=1 at edge k -> CLEAR (do_clear=1) or LOAD; first phase output high from edge k+1.
//   CLEAR: clear=1 for 1 tick -> LOAD.   LOAD: load=1 for 1 tick -> SHIFT_HI, bit_cnt=0.
//   SHIFT_HI: shift_clk=1 for 1 tick -> SHIFT_LO.
//   SHIFT_LO: shift_clk=0 for 1 tick; bit_cnt==CHAIN_LEN-1 -> SAVE, else bit_cnt++ -> SHIFT_HI.
//   SAVE: save_data=1, done=1, scan_cnt++ for exactly 1 CLK -> IDLE.
// - Scan length (no clear): SHIFT_DIV*(1+2*CHAIN_LEN)+1 cycles; +SHIFT_DIV with clear.
// - Phases are mutually exclusive: never two of clear/load/shift_clk/save_data high at once.
// - start while busy: ignored, no queueing. start and abort same cycle in IDLE: abort wins, stay IDLE.
// - abort: next edge IDLE, all outputs 0, scan_cnt unchanged, no done/save_data; abort during SAVE cycle still counts that scan (SAVE already committed).
// - RST_B low mid-scan: immediate return to reset values; no partial save.
// - bit_cnt width $clog2(CHAIN_LEN+1); tick counter width $clog2(SHIFT_DIV+1).
// CONFIGURATION
// - DFF_SCAN_CONT_EN defined: in SAVE, cont=1 -> next state LOAD (no CLEAR, tick counter restarted), busy stays 1; cont=0 -> IDLE.
// - DFF_SCAN_CONT_EN undefined: cont ignored, SAVE always -> IDLE; behaviour otherwise identical.
// STRUCTURE
// - Package dff_scan_pkg: state enum (IDLE..SAVE, 3-bit), default CHAIN_LEN/SHIFT_DIV constants.
// - Sub-module scan_tick_gen: SHIFT_DIV prescaler with sync restart input and tick output.
// - FSM, bit counter, scan counter and output registers in dff_scan_seq.
// TESTING (CHAIN_LEN=16, SHIFT_DIV=4, CNT_W=16 unless noted)
// - start@k, do_clear=0 -> load high k+1..k+4; 16 shift_clk rising edges, first at k+5; save_data/done only at k+133; scan_cnt=1.
// - start@k, do_clear=1 -> clear high k+1..k+4, load k+5..k+8, save at k+137; no output overlap.
// - start pulsed every cycle during scan -> exactly one scan, scan_cnt +1 only.
// - abort after 7th shift_clk edge -> IDLE next cycle, outputs 0, no save_data, scan_cnt unchanged; next start gives full 16 pulses.
// - SHIFT_DIV=1, CHAIN_LEN=1 -> load 1 cycle, shift_clk 1 high/1 low, save at k+4; CNT_W=2 four scans -> scan_cnt wraps 3->0.
// - DFF_SCAN_CONT_EN, cont=1 -> back-to-back scans, busy never drops, load follows save next cycle; cont=0 -> IDLE after current scan.

Source files
------------

// File: rtl/dff_scan_pkg.sv
// rtl/dff_scan_pkg.sv - state encoding and default sizing for the DFF-chain scan sequencer
package dff_scan_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        LOAD     = 3'd2,
        SHIFT_HI = 3'd3,
        SHIFT_LO = 3'd4,
        SAVE     = 3'd5
    } scan_state_e;

    localparam int DEF_CHAIN_LEN = 16;
    localparam int DEF_SHIFT_DIV = 4;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - SHIFT_DIV prescaler; tick marks the last cycle of every phase tick
module scan_tick_gen
    import dff_scan_pkg::*;
#(
    parameter int SHIFT_DIV = DEF_SHIFT_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            TW   = $clog2(SHIFT_DIV + 1);
    localparam logic [TW-1:0] TERM = TW'(SHIFT_DIV - 1);

    logic [TW-1:0] cnt_q;

    assign tick_o = (cnt_q == TERM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (restart_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/dff_scan_seq.sv
// rtl/dff_scan_seq.sv - PISO readout sequencer: clear/load/shift_clk/save_data from one start strobe
// Optional back-to-back rescans when DFF_SCAN_CONT_EN is defined.
module dff_scan_seq
    import dff_scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int SHIFT_DIV = DEF_SHIFT_DIV,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             start,
    input  logic             do_clear,
    input  logic             abort,
    input  logic             cont,
    output logic             clear,
    output logic             load,
    output logic             shift_clk,
    output logic             save_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] scan_cnt
);

    localparam int            BW       = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    scan_state_e      state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] scan_cnt_q;
    logic             clear_q, load_q, shift_q, save_q, busy_q;
    logic             tick;
    logic             tick_restart;
    logic             rescan;

    // Prescaler is held at zero in IDLE and SAVE so every scan's first phase gets a full tick.
    assign tick_restart = (state_q == IDLE) || (state_q == SAVE);

    scan_tick_gen #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_tick (
        .clk_i     (CLK),
        .rst_ni    (RST_B),
        .restart_i (tick_restart),
        .tick_o    (tick)
    );

`ifdef DFF_SCAN_CONT_EN
    assign rescan = cont;
`else
    logic unused_cont;
    assign unused_cont = cont;
    assign rescan      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (start) state_d = do_clear ? CLEAR : LOAD;
                CLEAR:    if (tick) state_d = LOAD;
                LOAD: begin
                    if (tick) begin
                        state_d   = SHIFT_HI;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT_HI: if (tick) state_d = SHIFT_LO;
                SHIFT_LO: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = SAVE;
                        end else begin
                            state_d   = SHIFT_HI;
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                SAVE:     state_d = rescan ? LOAD : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the edge entering each state.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            scan_cnt_q <= '0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            save_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            clear_q   <= (state_d == CLEAR);
            load_q    <= (state_d == LOAD);
            shift_q   <= (state_d == SHIFT_HI);
            save_q    <= (state_d == SAVE);
            busy_q    <= (state_d != IDLE);
            if (state_d == SAVE) begin
                scan_cnt_q <= scan_cnt_q + CNT_W'(1);
            end
        end
    end

    assign clear     = clear_q;
    assign load      = load_q;
    assign shift_clk = shift_q;
    assign save_data = save_q;
    assign done      = save_q;
    assign busy      = busy_q;
    assign scan_cnt  = scan_cnt_q;

endmodule

// File: tb/tb_dff_scan_seq.sv
// tb/tb_dff_scan_seq.sv - bench for dff_scan_seq: 16x4 and 1x1 (CNT_W=2) instances vs a phase-schedule model
module tb_dff_scan_seq;

`ifdef DFF_SCAN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_B;
    logic        st[2], dc[2], ab[2], co[2];
    logic        clr_o[2], ld_o[2], sh_o[2], sv_o[2], bz_o[2], dn_o[2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int cl_v[2] = '{16, 1};
    int sd_v[2] = '{4, 1};
    int cw_v[2] = '{16, 2};

    bit m_act[2], m_clr[2];
    int m_t[2], m_cnt[2];

    int n_checks = 0, n_fail = 0, cyc = 0;
    bit prev_sh[2], prev_sv[2];
    int rise_cnt[2], sv_cnt[2], last_save_cyc[2], first_rise[2], bz_low[2], ld_after_sv[2];

    always #5 CLK = ~CLK;

    dff_scan_seq #(.CHAIN_LEN(16), .SHIFT_DIV(4), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_B(RST_B), .start(st[0]), .do_clear(dc[0]), .abort(ab[0]), .cont(co[0]),
        .clear(clr_o[0]), .load(ld_o[0]), .shift_clk(sh_o[0]), .save_data(sv_o[0]),
        .busy(bz_o[0]), .done(dn_o[0]), .scan_cnt(cnt0)
    );

    dff_scan_seq #(.CHAIN_LEN(1), .SHIFT_DIV(1), .CNT_W(2)) u_dut_small (
        .CLK(CLK), .RST_B(RST_B), .start(st[1]), .do_clear(dc[1]), .abort(ab[1]), .cont(co[1]),
        .clear(clr_o[1]), .load(ld_o[1]), .shift_clk(sh_o[1]), .save_data(sv_o[1]),
        .busy(bz_o[1]), .done(dn_o[1]), .scan_cnt(cnt1)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scan_len(int cl, int sd, bit clr);
        return sd * (1 + 2 * cl) + 1 + (clr ? sd : 0);
    endfunction

    // {clear, load, shift_clk, save_data} expected t cycles into a scan (t=1 is the first phase cycle)
    function automatic logic [3:0] phase_out(int cl, int sd, bit clr, int t);
        int off;
        off = t - 1;
        if (clr) begin
            if (off < sd) return 4'b1000;
            off -= sd;
        end
        if (off < sd) return 4'b0100;
        off -= sd;
        if (off < 2 * sd * cl) return ((off % (2 * sd)) < sd) ? 4'b0010 : 4'b0000;
        if (off == 2 * sd * cl) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic model_step(input int i);
        if (m_act[i]) begin
            if (ab[i]) begin
                m_act[i] = 1'b0;
            end else if (m_t[i] == scan_len(cl_v[i], sd_v[i], m_clr[i])) begin
                if (CONT && co[i]) begin
                    m_t[i]   = 1;
                    m_clr[i] = 1'b0;
                end else begin
                    m_act[i] = 1'b0;
                end
            end else begin
                m_t[i]++;
            end
        end else if (st[i] && !ab[i]) begin
            m_act[i] = 1'b1;
            m_t[i]   = 1;
            m_clr[i] = dc[i];
        end
        if (m_act[i] && phase_out(cl_v[i], sd_v[i], m_clr[i], m_t[i]) == 4'b0001) m_cnt[i]++;
    endtask

    task automatic check_dut(input int i);
        logic [3:0] exp_o, obs_o;
        int obs_cnt;
        exp_o   = m_act[i] ? phase_out(cl_v[i], sd_v[i], m_clr[i], m_t[i]) : 4'b0000;
        obs_o   = {clr_o[i], ld_o[i], sh_o[i], sv_o[i]};
        obs_cnt = (i == 0) ? int'(cnt0) : int'(cnt1);
        check_eq($sformatf("d%0d.clear@%0d", i, cyc), int'(obs_o[3]), int'(exp_o[3]));
        check_eq($sformatf("d%0d.load@%0d", i, cyc), int'(obs_o[2]), int'(exp_o[2]));
        check_eq($sformatf("d%0d.shift@%0d", i, cyc), int'(obs_o[1]), int'(exp_o[1]));
        check_eq($sformatf("d%0d.save@%0d", i, cyc), int'(obs_o[0]), int'(exp_o[0]));
        check_eq($sformatf("d%0d.done@%0d", i, cyc), int'(dn_o[i]), int'(exp_o[0]));
        check_eq($sformatf("d%0d.busy@%0d", i, cyc), int'(bz_o[i]), int'(m_act[i]));
        check_eq($sformatf("d%0d.cnt@%0d", i, cyc), obs_cnt, m_cnt[i] % (1 << cw_v[i]));
        check_eq($sformatf("d%0d.overlap@%0d", i, cyc), int'($countones(obs_o) > 1), 0);
        if (sh_o[i] && !prev_sh[i]) begin
            rise_cnt[i]++;
            if (first_rise[i] < 0) first_rise[i] = cyc;
        end
        if (sv_o[i]) begin
            sv_cnt[i]++;
            last_save_cyc[i] = cyc;
        end
        if (!bz_o[i]) bz_low[i]++;
        if (prev_sv[i] && ld_o[i]) ld_after_sv[i]++;
        prev_sh[i] = sh_o[i];
        prev_sv[i] = sv_o[i];
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int i = 0; i < 2; i++) model_step(i);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) check_dut(i);
    endtask

    task automatic run_scan(input int i, input bit clr, input int ncyc);
        st[i] = 1'b1;
        dc[i] = clr;
        tick();
        st[i] = 1'b0;
        dc[i] = 1'b0;
        repeat (ncyc - 1) tick();
    endtask

    initial begin
        int k, r0, s0, b0, l0, n;
        RST_B = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; dc[i] = 0; ab[i] = 0; co[i] = 0;
            m_act[i] = 0; m_clr[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
            prev_sh[i] = 0; prev_sv[i] = 0; rise_cnt[i] = 0; sv_cnt[i] = 0;
            last_save_cyc[i] = -1; first_rise[i] = -1; bz_low[i] = 0; ld_after_sv[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst.busy", int'(bz_o[0]), 0);
        check_eq("rst.outs", int'({clr_o[0], ld_o[0], sh_o[0], sv_o[0], dn_o[0]}), 0);
        check_eq("rst.cnt", int'(cnt0), 0);
        check_eq("rst.small_outs", int'({clr_o[1], ld_o[1], sh_o[1], sv_o[1], bz_o[1], cnt1}), 0);
        @(negedge CLK);
        RST_B = 1'b1;
        tick();

        // plain scan
        k = cyc; r0 = rise_cnt[0]; first_rise[0] = -1;
        run_scan(0, 1'b0, 136);
        check_eq("a.rises", rise_cnt[0] - r0, 16);
        check_eq("a.first_rise", first_rise[0] - k, 5);
        check_eq("a.save_cyc", last_save_cyc[0] - k, 133);
        check_eq("a.cnt", int'(cnt0), 1);

        // scan with clear
        k = cyc; r0 = rise_cnt[0]; first_rise[0] = -1;
        run_scan(0, 1'b1, 140);
        check_eq("b.rises", rise_cnt[0] - r0, 16);
        check_eq("b.first_rise", first_rise[0] - k, 9);
        check_eq("b.save_cyc", last_save_cyc[0] - k, 137);
        check_eq("b.cnt", int'(cnt0), 2);

        // start held through the whole scan
        s0 = sv_cnt[0];
        st[0] = 1'b1;
        repeat (134) tick();
        st[0] = 1'b0;
        repeat (5) tick();
        check_eq("c.saves", sv_cnt[0] - s0, 1);
        check_eq("c.cnt", int'(cnt0), 3);

        // abort after the 7th shift_clk edge
        r0 = rise_cnt[0]; s0 = sv_cnt[0];
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        n = 0;
        while (rise_cnt[0] - r0 < 7 && n < 200) begin
            tick();
            n++;
        end
        check_eq("d.reach7", rise_cnt[0] - r0, 7);
        ab[0] = 1'b1; tick(); ab[0] = 1'b0;
        check_eq("d.busy", int'(bz_o[0]), 0);
        check_eq("d.shift", int'(sh_o[0]), 0);
        repeat (140) tick();
        check_eq("d.saves", sv_cnt[0] - s0, 0);
        check_eq("d.cnt", int'(cnt0), 3);
        r0 = rise_cnt[0];
        run_scan(0, 1'b0, 136);
        check_eq("d.rises_after", rise_cnt[0] - r0, 16);
        check_eq("d.cnt_after", int'(cnt0), 4);

        // start and abort together in IDLE
        st[0] = 1'b1; ab[0] = 1'b1; tick(); st[0] = 1'b0; ab[0] = 1'b0;
        check_eq("e.start_abort_busy", int'(bz_o[0]), 0);

        // 1x1 instance: short scan and counter wrap
        k = cyc;
        run_scan(1, 1'b0, 5);
        check_eq("f.save_cyc", last_save_cyc[1] - k, 4);
        run_scan(1, 1'b0, 5);
        run_scan(1, 1'b0, 5);
        check_eq("f.cnt3", int'(cnt1), 3);
        run_scan(1, 1'b1, 6);
        check_eq("f.wrap", int'(cnt1), 0);

        // continuous rescan request
        s0 = sv_cnt[0]; b0 = bz_low[0]; l0 = ld_after_sv[0];
        co[0] = 1'b1;
        run_scan(0, 1'b0, 400);
        check_eq("g.saves", sv_cnt[0] - s0, CONT ? 3 : 1);
        check_eq("g.busy_low", bz_low[0] - b0, CONT ? 0 : 267);
        check_eq("g.load_after_save", ld_after_sv[0] - l0, CONT ? 3 : 0);
        co[0] = 1'b0;
        repeat (140) tick();
        check_eq("g.saves_end", sv_cnt[0] - s0, CONT ? 4 : 1);
        check_eq("g.idle_end", int'(bz_o[0]), 0);

        // reset mid-scan
        st[0] = 1'b1; st[1] = 1'b1; tick(); st[0] = 1'b0; st[1] = 1'b0;
        repeat (50) tick();
        RST_B = 1'b0;
        #1;
        check_eq("h.busy", int'(bz_o[0]), 0);
        check_eq("h.outs", int'({clr_o[0], ld_o[0], sh_o[0], sv_o[0], dn_o[0]}), 0);
        check_eq("h.cnt", int'(cnt0), 0);
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_cnt[i] = 0; prev_sh[i] = 0; prev_sv[i] = 0;
        end
        @(negedge CLK);
        RST_B = 1'b1;
        tick();

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(7) == 0);
                dc[i] = $urandom_range(1);
                ab[i] = ($urandom_range(99) == 0);
                co[i] = $urandom_range(1);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; ab[i] = 0; co[i] = 0;
        end
        repeat (150) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
